simple_bram_ctrl_fsm: RTL and testbench
=======================================

// Module: simple_bram_ctrl_fsm
// PURPOSE
//  Self-contained BRAM exerciser: on a start pulse, writes N words to a single-clock
//  BRAM port (addr k <- data k), then reads the same N words back and streams them out
//  with a valid strobe. Drives port A of a true dual-port BRAM (1-cycle read latency);
//  port B stays unused. Sits between a simple run/done control block and the memory.
// PARAMETERS
//  DWIDTH    16   data width of BRAM word and o_mem_data
//  AWIDTH    7    address width; also width of i_num_cnt
//  MEM_SIZE  128  BRAM depth in words (2**AWIDTH)
// PORTS
//  clk         in   1       rising-edge clock
//  reset_n     in   1       reset; asynchronous and active-low
//  i_run       in   1       start pulse, sampled only in IDLE
//  i_num_cnt   in   AWIDTH  word count N, latched on accepted i_run
//  o_idle      out  1       high in IDLE
//  o_write     out  1       high in WRITE
//  o_read      out  1       high in READ
//  o_done      out  1       one-cycle pulse in DONE
//  addr0       out  AWIDTH  BRAM port A address
//  ce0         out  1       BRAM port A chip enable
//  we0         out  1       BRAM port A write enable
//  q0          in   DWIDTH  BRAM port A read data (valid 1 cycle after read ce0)
//  d0          out  DWIDTH  BRAM port A write data
//  o_valid     out  1       o_mem_data qualifier
//  o_mem_data  out  DWIDTH  read-back word (= q0 while o_valid)
// BEHAVIOUR
//  - States IDLE->WRITE->READ->DONE->IDLE; o_idle/o_write/o_read/o_done decode state reg.
//  - Reset (async, any time incl. mid-operation): state=IDLE, counter=0, latched N=0,
//    o_valid=0; so o_idle=1, all other outputs 0. No pending access survives reset.
//  - IDLE: i_run=1 latches N=i_num_cnt; N!=0 -> WRITE, N==0 -> DONE directly.
//    i_run outside IDLE ignored; i_num_cnt changes after latch ignored.
//  - WRITE: counter k=0..N-1, one word/cycle: ce0=1, we0=1, addr0=k, d0=k zero-extended.
//    At k==N-1 -> READ, k cleared. Exactly N write cycles.
//  - READ: k=0..N-1: ce0=1, we0=0, addr0=k. At k==N-1 -> DONE. Exactly N read cycles.
//  - o_valid = registered (ce0 & !we0), i.e. one cycle after each read issue;
//    o_mem_data = q0. Last valid word lands in the DONE cycle. N valid pulses total.
//  - DONE: single cycle, o_done=1, ce0=0, then IDLE.
//  - ce0=we0=0, addr0=0, d0=0 in IDLE/DONE. Max N = 2**AWIDTH-1; no address wrap.
//  - Latency i_run -> o_done: 2N+1 cycles (N>0); 1 cycle for N=0.
// CONFIGURATION
//  BRAM_CTRL_RD_CHECK_EN defined: adds output o_err (1 bit, reset 0); when o_valid and
//   o_mem_data != expected index, o_err sets and stays set until reset or next accepted
//   i_run (cleared on start). Undefined: no o_err port, no compare logic.
// TESTING
//  - Reset pulse (100 ns in, 10 ns low) -> o_idle=1, ce0=we0=o_valid=o_done=0.
//  - i_run 1 cycle, N=100 -> 100 cycles we0=1 addr0=d0=0..99, then 100 read cycles,
//    o_valid x100 with o_mem_data 0..99 in order, o_done pulse at cycle 201, back to idle.
//  - N=1 -> 1 write (addr 0, data 0), 1 read, o_valid once with data 0, o_done after 3 cycles.
//  - N=0 -> no ce0 activity, o_done next cycle, o_idle after.
//  - i_run asserted during WRITE/READ -> ignored, sequence unaltered; async reset during
//    READ (N=100) -> immediate IDLE, outputs 0, fresh run N=5 completes normally.
//  - RD_CHECK_EN: normal run -> o_err=0; force q0 bit flip -> o_err=1 sticky until next run.

Source files
------------

// File: rtl/simple_bram_ctrl_fsm.sv
// ============================================================================
// Module   : simple_bram_ctrl_fsm
// Brief    : BRAM exerciser, writes N words (addr k <- k), reads them back and
//            streams them out. Optional read-back checker: BRAM_CTRL_RD_CHECK_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module simple_bram_ctrl_fsm #(
    parameter int DWIDTH   = 16,
    parameter int AWIDTH   = 7,
    parameter int MEM_SIZE = 128
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_run,
    input  logic [AWIDTH-1:0] i_num_cnt,
    output logic              o_idle,
    output logic              o_write,
    output logic              o_read,
    output logic              o_done,
    output logic [AWIDTH-1:0] addr0,
    output logic              ce0,
    output logic              we0,
    input  logic [DWIDTH-1:0] q0,
    output logic [DWIDTH-1:0] d0,
    output logic              o_valid,
`ifdef BRAM_CTRL_RD_CHECK_EN
    output logic              o_err,
`endif
    output logic [DWIDTH-1:0] o_mem_data
);

    // Word count is limited to what both the address range and the memory hold.
    localparam int MAX_N = (MEM_SIZE < (2**AWIDTH)) ? MEM_SIZE : (2**AWIDTH) - 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_READ  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [AWIDTH-1:0] cnt_q, cnt_d;
    logic [AWIDTH-1:0] num_q, num_d;
    logic              valid_q, valid_d;
    logic [AWIDTH-1:0] run_num;
    logic              last;

    assign run_num = (int'(i_num_cnt) > MAX_N) ? AWIDTH'(MAX_N) : i_num_cnt;
    assign last    = (cnt_q == num_q - AWIDTH'(1));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        num_d   = num_q;
        ce0     = 1'b0;
        we0     = 1'b0;
        addr0   = '0;
        d0      = '0;
        case (state_q)
            S_IDLE: begin
                if (i_run) begin
                    num_d   = run_num;
                    cnt_d   = '0;
                    state_d = (run_num == '0) ? S_DONE : S_WRITE;
                end
            end
            S_WRITE: begin
                ce0   = 1'b1;
                we0   = 1'b1;
                addr0 = cnt_q;
                d0    = DWIDTH'(cnt_q);
                if (last) begin
                    cnt_d   = '0;
                    state_d = S_READ;
                end else begin
                    cnt_d = cnt_q + AWIDTH'(1);
                end
            end
            S_READ: begin
                ce0   = 1'b1;
                addr0 = cnt_q;
                if (last) begin
                    cnt_d   = '0;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + AWIDTH'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        valid_d = ce0 & ~we0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            num_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            num_q   <= num_d;
            valid_q <= valid_d;
        end
    end

    assign o_idle     = (state_q == S_IDLE);
    assign o_write    = (state_q == S_WRITE);
    assign o_read     = (state_q == S_READ);
    assign o_done     = (state_q == S_DONE);
    assign o_valid    = valid_q;
    assign o_mem_data = q0;

`ifdef BRAM_CTRL_RD_CHECK_EN
    // Address of the read in flight, aligned with q0 when o_valid is high.
    logic [AWIDTH-1:0] rd_idx_q, rd_idx_d;
    logic              err_q, err_d;

    always_comb begin
        rd_idx_d = addr0;
        err_d    = err_q;
        if ((state_q == S_IDLE) && i_run) begin
            err_d = 1'b0;
        end else if (valid_q && (q0 != DWIDTH'(rd_idx_q))) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_idx_q <= '0;
            err_q    <= 1'b0;
        end else begin
            rd_idx_q <= rd_idx_d;
            err_q    <= err_d;
        end
    end

    assign o_err = err_q;
`else
`endif

endmodule

`default_nettype wire

// File: tb/tb_simple_bram_ctrl_fsm.sv
// ============================================================================
// Module   : tb_simple_bram_ctrl_fsm
// Brief    : Scoreboard bench for simple_bram_ctrl_fsm with a 1-cycle BRAM model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_simple_bram_ctrl_fsm;

    localparam int DWIDTH = 16;
    localparam int AWIDTH = 7;

    logic              clk;
    logic              reset_n;
    logic              i_run;
    logic [AWIDTH-1:0] i_num_cnt;
    logic              o_idle, o_write, o_read, o_done;
    logic [AWIDTH-1:0] addr0;
    logic              ce0, we0, o_valid;
    logic [DWIDTH-1:0] q0, d0, o_mem_data;
`ifdef BRAM_CTRL_RD_CHECK_EN
    logic              o_err;
`endif

    logic [DWIDTH-1:0] mem [0:(2**AWIDTH)-1];
    logic [DWIDTH-1:0] q_reg;
    logic              flip;

    int n_checks = 0;
    int n_fail   = 0;

    int wq[$];
    int rq[$];
    int vq[$];

    simple_bram_ctrl_fsm #(
        .DWIDTH  (DWIDTH),
        .AWIDTH  (AWIDTH),
        .MEM_SIZE(128)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_run     (i_run),
        .i_num_cnt (i_num_cnt),
        .o_idle    (o_idle),
        .o_write   (o_write),
        .o_read    (o_read),
        .o_done    (o_done),
        .addr0     (addr0),
        .ce0       (ce0),
        .we0       (we0),
        .q0        (q0),
        .d0        (d0),
        .o_valid   (o_valid),
`ifdef BRAM_CTRL_RD_CHECK_EN
        .o_err     (o_err),
`endif
        .o_mem_data(o_mem_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ce0 === 1'b1 && we0 === 1'b1) mem[addr0] <= d0;
        if (ce0 === 1'b1 && we0 === 1'b0) q_reg <= mem[addr0];
    end
    assign q0 = q_reg ^ {{(DWIDTH-1){1'b0}}, flip};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every port-A access and every valid word is matched against the queues.
    always @(negedge clk) begin
        if (reset_n === 1'b1) begin
            if (ce0 === 1'b1 && we0 === 1'b1) begin
                check("wr_expected", 32'(wq.size() > 0), 32'd1);
                if (wq.size() > 0) begin
                    int e;
                    e = wq.pop_front();
                    check("wr_addr", 32'(addr0), 32'(e));
                    check("wr_data", 32'(d0), 32'(e));
                end
            end else if (ce0 === 1'b1) begin
                check("rd_expected", 32'(rq.size() > 0), 32'd1);
                if (rq.size() > 0) begin
                    int e;
                    e = rq.pop_front();
                    check("rd_addr", 32'(addr0), 32'(e));
                    check("rd_we", 32'(we0), 32'd0);
                end
            end
            if (o_valid === 1'b1) begin
                check("valid_expected", 32'(vq.size() > 0), 32'd1);
                if (vq.size() > 0) begin
                    int e;
                    e = vq.pop_front();
                    check("mem_data", 32'(o_mem_data), 32'(e));
                end
            end
        end
    end

    task automatic check_quiet(input string tag);
        check({tag, "_idle"},  32'(o_idle),  32'd1);
        check({tag, "_ce0"},   32'(ce0),     32'd0);
        check({tag, "_we0"},   32'(we0),     32'd0);
        check({tag, "_valid"}, 32'(o_valid), 32'd0);
        check({tag, "_done"},  32'(o_done),  32'd0);
        check({tag, "_addr0"}, 32'(addr0),   32'd0);
    endtask

    task automatic do_run(input int n, input bit glitch, input bit flip_it);
        int lat;
        @(posedge clk); #1;
        i_run     = 1'b1;
        i_num_cnt = AWIDTH'(n);
        flip      = flip_it;
        for (int i = 0; i < n; i++) begin
            wq.push_back(i);
            rq.push_back(i);
            vq.push_back(flip_it ? (i ^ 1) : i);
        end
        @(posedge clk); #1;
        i_run     = 1'b0;
        i_num_cnt = 7'h55;
        lat = 1;
        while (o_done !== 1'b1 && lat < 400) begin
            @(posedge clk); #1;
            lat++;
            if (glitch) begin
                if (lat == 4 || lat == n + 4) begin
                    i_run     = 1'b1;
                    i_num_cnt = 7'd3;
                end else begin
                    i_run = 1'b0;
                end
            end
        end
        i_run = 1'b0;
        check("latency", 32'(lat), (n == 0) ? 32'd1 : 32'(2 * n + 1));
        check("done_pulse", 32'(o_done), 32'd1);
        check("done_ce0", 32'(ce0), 32'd0);
        @(posedge clk); #1;
        check("wq_drained", 32'(wq.size()), 32'd0);
        check("rq_drained", 32'(rq.size()), 32'd0);
        check("vq_drained", 32'(vq.size()), 32'd0);
        check_quiet("post_run");
        flip = 1'b0;
    endtask

    initial begin
        reset_n   = 1'b1;
        i_run     = 1'b0;
        i_num_cnt = '0;
        flip      = 1'b0;
        q_reg     = '0;
        #101;
        reset_n = 1'b0;
        #2;
        check_quiet("reset");
        check("reset_write", 32'(o_write), 32'd0);
        check("reset_read",  32'(o_read),  32'd0);
        check("reset_d0",    32'(d0),      32'd0);
        #8;
        reset_n = 1'b1;
        #2;
        check_quiet("after_reset");
`ifdef BRAM_CTRL_RD_CHECK_EN
        check("reset_err", 32'(o_err), 32'd0);
`endif

        do_run(100, 1'b0, 1'b0);
        do_run(1, 1'b0, 1'b0);
        do_run(0, 1'b0, 1'b0);
        do_run(20, 1'b1, 1'b0);

        // Asynchronous reset in the middle of the read phase.
        @(posedge clk); #1;
        i_run     = 1'b1;
        i_num_cnt = 7'd100;
        for (int i = 0; i < 100; i++) begin
            wq.push_back(i);
            rq.push_back(i);
            vq.push_back(i);
        end
        @(posedge clk); #1;
        i_run = 1'b0;
        repeat (150) @(posedge clk);
        #1;
        check("mid_read_state", 32'(o_read), 32'd1);
        #2;
        reset_n = 1'b0;
        wq.delete();
        rq.delete();
        vq.delete();
        #1;
        check_quiet("async_reset");
        check("async_reset_read", 32'(o_read), 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        check_quiet("async_release");
        do_run(5, 1'b0, 1'b0);

`ifdef BRAM_CTRL_RD_CHECK_EN
        check("err_clean", 32'(o_err), 32'd0);
        do_run(4, 1'b0, 1'b1);
        check("err_set", 32'(o_err), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        check("err_sticky", 32'(o_err), 32'd1);
        do_run(3, 1'b0, 1'b0);
        check("err_cleared", 32'(o_err), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
